// File: rtl/fifo_mc_df_if.sv
// Push/pop/status bundle for the multi-channel FIFO.
// The master side drives requests and levels; the slave side is the FIFO itself.
interface fifo_mc_df_if #(
  parameter int width    = 8,
  parameter int depth    = 8,
  parameter int channels = 4
);
  localparam int cnt_w = $clog2(depth) + 1;
  localparam int ch_w  = $clog2(channels);

  logic [channels-1:0]       clr;
  logic                      push_n;
  logic [ch_w-1:0]           push_ch;
  logic [width-1:0]          data_in;
  logic                      pop_n;
  logic [ch_w-1:0]           pop_ch;
  logic [cnt_w-1:0]          ae_level;
  logic [cnt_w-1:0]          af_level;
  logic [width-1:0]          data_out;
  logic                      data_valid;
  logic [ch_w-1:0]           data_ch;
  logic [channels*cnt_w-1:0] word_cnt;
  logic [channels-1:0]       empty;
  logic [channels-1:0]       almost_empty;
  logic [channels-1:0]       half_full;
  logic [channels-1:0]       almost_full;
  logic [channels-1:0]       full;
  logic [channels-1:0]       error;

  modport master (
    output clr, push_n, push_ch, data_in, pop_n, pop_ch, ae_level, af_level,
    input  data_out, data_valid, data_ch, word_cnt, empty, almost_empty,
           half_full, almost_full, full, error
  );

  modport slave (
    input  clr, push_n, push_ch, data_in, pop_n, pop_ch, ae_level, af_level,
    output data_out, data_valid, data_ch, word_cnt, empty, almost_empty,
           half_full, almost_full, full, error
  );
endinterface

// File: rtl/fifo_mc_df.sv
// Single-clock multi-channel FIFO: one RAM split into per-channel circular queues,
// one shared push port and one shared pop port, dynamic almost-empty/full thresholds.
module fifo_mc_df #(
  parameter int width    = 8,
  parameter int depth    = 8,
  parameter int channels = 4,
  parameter int err_mode = 0
) (
  input logic         i_clk,
  input logic         i_rst_n,
  fifo_mc_df_if.slave io_bus
);
  localparam int aw    = $clog2(depth);
  localparam int cnt_w = aw + 1;
  localparam int ch_w  = $clog2(channels);
  localparam logic [cnt_w-1:0] lp_depth = cnt_w'(depth);
  localparam logic [cnt_w-1:0] lp_half  = cnt_w'(depth / 2);

  logic [width-1:0]    r_mem [0:channels*depth-1];
  logic [aw-1:0]       r_wr_ptr [channels];
  logic [aw-1:0]       r_rd_ptr [channels];
  logic [cnt_w-1:0]    r_count  [channels];
  logic [channels-1:0] r_err;
  logic [width-1:0]    r_data_out;
  logic                r_data_valid;
  logic [ch_w-1:0]     r_data_ch;

  logic                w_push_req;
  logic                w_pop_req;
  logic                w_push_ok;
  logic                w_pop_ok;
  logic [channels-1:0] w_push_hit;
  logic [channels-1:0] w_pop_hit;
  logic [channels-1:0] w_err_set;
  logic [ch_w+aw-1:0]  w_wr_addr;
  logic [ch_w+aw-1:0]  w_rd_addr;

  logic [channels*cnt_w-1:0] w_word_cnt;
  logic [channels-1:0]       w_empty;
  logic [channels-1:0]       w_almost_empty;
  logic [channels-1:0]       w_half_full;
  logic [channels-1:0]       w_almost_full;
  logic [channels-1:0]       w_full;

  always_comb begin
    w_push_req = !io_bus.push_n && (32'(io_bus.push_ch) < channels) && !io_bus.clr[io_bus.push_ch];
    w_pop_req  = !io_bus.pop_n  && (32'(io_bus.pop_ch)  < channels) && !io_bus.clr[io_bus.pop_ch];
    w_pop_ok   = w_pop_req && (r_count[io_bus.pop_ch] != '0);
    // A full channel still accepts a push when the same channel is popped this cycle.
    w_push_ok  = w_push_req && ((r_count[io_bus.push_ch] != lp_depth) ||
                                (w_pop_ok && (io_bus.pop_ch == io_bus.push_ch)));
    w_wr_addr  = {io_bus.push_ch, r_wr_ptr[io_bus.push_ch]};
    w_rd_addr  = {io_bus.pop_ch, r_rd_ptr[io_bus.pop_ch]};
    w_push_hit = '0;
    w_pop_hit  = '0;
    w_err_set  = '0;
    for (int k = 0; k < channels; k++) begin
      w_push_hit[k] = w_push_ok && (io_bus.push_ch == ch_w'(k));
      w_pop_hit[k]  = w_pop_ok  && (io_bus.pop_ch  == ch_w'(k));
    end
    if (w_push_req && !w_push_ok) w_err_set[io_bus.push_ch] = 1'b1;
    if (w_pop_req && !w_pop_ok)   w_err_set[io_bus.pop_ch]  = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k < channels; k++) begin
        r_wr_ptr[k] <= '0;
        r_rd_ptr[k] <= '0;
        r_count[k]  <= '0;
      end
      r_err        <= '0;
      r_data_valid <= 1'b0;
      r_data_out   <= '0;
      r_data_ch    <= '0;
    end else begin
      r_data_valid <= w_pop_ok;
      if (w_pop_ok) begin
        r_data_out <= r_mem[w_rd_addr];
        r_data_ch  <= io_bus.pop_ch;
      end
      for (int k = 0; k < channels; k++) begin
        if (io_bus.clr[k]) begin
          r_wr_ptr[k] <= '0;
          r_rd_ptr[k] <= '0;
          r_count[k]  <= '0;
          r_err[k]    <= 1'b0;
        end else begin
          if (w_push_hit[k]) r_wr_ptr[k] <= r_wr_ptr[k] + aw'(1);
          if (w_pop_hit[k])  r_rd_ptr[k] <= r_rd_ptr[k] + aw'(1);
          if (w_push_hit[k] && !w_pop_hit[k])
            r_count[k] <= r_count[k] + cnt_w'(1);
          else if (!w_push_hit[k] && w_pop_hit[k])
            r_count[k] <= r_count[k] - cnt_w'(1);
          r_err[k] <= (err_mode != 0) ? w_err_set[k] : (r_err[k] | w_err_set[k]);
        end
      end
    end
  end

  // Nonblocking write keeps read-before-write when push and pop share an address.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_push_ok) r_mem[w_wr_addr] <= io_bus.data_in;
  end

  always_comb begin
    w_word_cnt     = '0;
    w_empty        = '0;
    w_almost_empty = '0;
    w_half_full    = '0;
    w_almost_full  = '0;
    w_full         = '0;
    for (int k = 0; k < channels; k++) begin
      w_word_cnt[k*cnt_w +: cnt_w] = r_count[k];
      w_empty[k]        = (r_count[k] == '0);
      w_full[k]         = (r_count[k] == lp_depth);
      w_almost_empty[k] = (r_count[k] <= io_bus.ae_level);
      w_half_full[k]    = (r_count[k] >= lp_half);
      w_almost_full[k]  = (io_bus.af_level > lp_depth) ||
                          (r_count[k] >= (lp_depth - io_bus.af_level));
    end
  end

  assign io_bus.data_out     = r_data_out;
  assign io_bus.data_valid   = r_data_valid;
  assign io_bus.data_ch      = r_data_ch;
  assign io_bus.word_cnt     = w_word_cnt;
  assign io_bus.empty        = w_empty;
  assign io_bus.almost_empty = w_almost_empty;
  assign io_bus.half_full    = w_half_full;
  assign io_bus.almost_full  = w_almost_full;
  assign io_bus.full         = w_full;
  assign io_bus.error        = r_err;
endmodule

// File: doc/fifo_mc_df.md
# fifo_mc_df

Single-clock, multi-channel synchronous FIFO with dynamic flag thresholds. One RAM is split into `channels` independent circular queues of `depth` words each, with one push port and one pop port shared by all channels. This is the single-clock, N-channel successor to the team's dual-clock dynamic-flag FIFO. It sits between packet classifiers and per-queue schedulers, where several logical streams share one storage macro.

## Interface
- `width`, default 8: data word width, 1..256.
- `depth`, default 8: words per channel; power of 2, 4..256.
- `channels`, default 4: number of queues, 2..16.
- `err_mode`, default 0: 0 = error bits are sticky until `clr` or reset; 1 = error bits pulse for one cycle.
- Derived widths:
  - `cnt_w = log2(depth)+1`
  - `ch_w = ceil(log2(channels))`
  - `aw = log2(depth)`
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset. Synchronous, active-low: sampled on the rising edge of `clk`.
- `clr`  in  `channels`  per-channel synchronous flush, active-high.
- `push_n`  in  1  push request, active-low.
- `push_ch`  in  `ch_w`  target channel of the push.
- `data_in`  in  `width`  write data.
- `pop_n`  in  1  pop request, active-low.
- `pop_ch`  in  `ch_w`  source channel of the pop.
- `ae_level`  in  `cnt_w`  almost-empty threshold; shared by all channels; dynamic.
- `af_level`  in  `cnt_w`  almost-full threshold, in words from full; dynamic.
- `data_out`  out  `width`  read data, registered.
- `data_valid`  out  1  high for one cycle when `data_out` carries popped data.
- `data_ch`  out  `ch_w`  channel that `data_out` came from.
- `word_cnt`  out  `channels*cnt_w`  per-channel occupancy; channel k occupies bits [k*cnt_w +: cnt_w].
- `empty`, `almost_empty`, `half_full`, `almost_full`, `full`  out  `channels` each  per-channel status flags.
- `error`  out  `channels`  per-channel overflow/underflow indicator.

## Operation
- Storage: RAM of `channels*depth` words. The address is `{ch, ptr[aw-1:0]}`.
- Per-channel state:
  - `wr_ptr` and `rd_ptr`, each `aw` bits, wrapping modulo `depth`.
  - `count`, `cnt_w` bits, range 0..`depth`.
- Push is accepted when `push_n==0` and `count[push_ch] < depth`. On acceptance, write `data_in` at `wr_ptr` and increment `wr_ptr`.
- Pop is accepted when `pop_n==0` and `count[pop_ch] > 0`. On acceptance, read at `rd_ptr` and increment `rd_ptr`. On the next cycle `data_valid=1` and `data_ch` = the popped channel.
- Count update per channel: +1 on push only, −1 on pop only, unchanged when both or neither are accepted.
- Same channel, simultaneous push and pop:
  - Channel empty: the pop is rejected as an underflow and the push is accepted. There is no fall-through.
  - Channel full: both are accepted. The read returns the old word (read-before-write at the shared address) and the count stays at `depth`.
- Different channels, simultaneous push and pop: the two channels are fully independent.
- Rejected push (channel full, and no same-channel pop accepted) sets `error[push_ch]`. Rejected pop sets `error[pop_ch]`.
  - `err_mode` 0: the error bit holds until `clr[k]` or reset.
  - `err_mode` 1: the error bit is high only in the cycle after the rejection.
- `clr[k]` flushes channel k: its pointers, count and error bit go to 0, and any push or pop to channel k in that cycle is discarded with no error. If the pop is discarded, no `data_valid` follows. Other channels are unaffected.
- Flags are combinational from the registered count, per channel k:
  - `empty` = (count==0)
  - `full` = (count==depth)
  - `almost_empty` = (count <= `ae_level`)
  - `almost_full` = (count >= depth − `af_level`); if `af_level` > depth, `almost_full`=1.
  - `half_full` = (count >= depth/2)
- All comparisons are unsigned at `cnt_w` bits. Level inputs may change on any cycle; the flags follow in the same cycle.

## Timing
- Reset (`rst_n==0` at an edge): all pointers and counts 0; `empty`=all 1, `almost_empty`=all 1 unless `ae_level`… evaluated combinationally (1 for count 0); `half_full`, `almost_full` (unless `af_level` >= depth), `full`, `error`, `data_valid`, `data_ch`, `data_out` = 0.
- Reset overrides every other input, including `clr`, push and pop.
- Reset asserted mid-operation discards queued data. `data_valid` goes to 0 at the next edge.
- Push latency: the count and flags change at the edge that accepts the push. The pushed word is poppable from the following cycle.
- Pop latency: `data_out` and `data_valid` are registered, 1 cycle after the accepting edge. `data_out` holds its value when `data_valid`=0.
- Throughput: one push and one pop per cycle, sustained, on any channel combination.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 to ch 2 and pop ch 2 three times:
  - `data_out` sequence 0x11, 0x22, 0x33, each with `data_valid`=1 and `data_ch`=2, one cycle after its pop.
  - `word_cnt` for ch 2 returns to 0 and `empty[2]`=1.
- Fill ch 0 with 8 words (`depth`=8), then push once more:
  - `full[0]`=1 and the 9th push is ignored.
  - `error[0]`=1 and stays 1 (`err_mode` 0) until `clr[0]` is pulsed, after which `error[0]`=0 and `word_cnt` for ch 0 =0.
- Ch 1 empty, simultaneous push(0xA5) and pop on ch 1:
  - The pop is rejected: `error[1]`=1 and no `data_valid`.
  - `word_cnt` for ch 1 =1. The next pop returns 0xA5.
- Ch 3 full, simultaneous push(0x77) and pop on ch 3:
  - The pop returns the oldest word and the count stays 8.
  - After 7 more pops, the 8th pop returns 0x77.
- `ae_level`=2, `af_level`=2, push 6 words to ch 0:
  - `almost_empty[0]` drops as the count goes 2→3; `half_full[0]` rises at count 4; `almost_full[0]` rises at count 6.
  - Changing `af_level` to 1 makes `almost_full[0]`=0 in the same cycle.
- Push to ch 0 and ch 1 on alternate cycles while popping ch 2, then assert `rst_n`=0 for one edge:
  - All `word_cnt` =0, `empty`=all 1, `data_valid`=0 on the edge after reset.
